// File: rtl/logic_pkg.sv
// Shared opcode encoding and evaluation function for the bitwise logic stage.
package logic_pkg;

    localparam int OP_W   = 3;
    // Evaluation is done at a fixed wide width; callers cast back down to their
    // own operand width, so inversions never leak past the result width.
    localparam int EVAL_W = 32;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 3'd7;

    function automatic logic [EVAL_W-1:0] logic_eval(
        input logic [OP_W-1:0]   op,
        input logic [EVAL_W-1:0] a,
        input logic [EVAL_W-1:0] b
    );
        logic [EVAL_W-1:0] r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            default:  r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_fifo.sv
// Small synchronous FIFO holding packed result/op/flag words.
// When empty, the output shows the last word popped (0 after reset).
module logic_fifo import logic_pkg::*; #(
    parameter int DW    = 10,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          push_en;
    logic          pop_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Head word, or the most recently popped word while empty.
    assign pop_data = empty ? hold_q : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy, storage and the empty-hold register.
    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            hold_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage array; contents are only read while occupied, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/logic_exec_stage.sv
// Registered, handshaked bitwise logic execution stage: one input register
// stage (S1) feeding an output FIFO of results with precomputed flags.
module logic_exec_stage import logic_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [OP_W-1:0]   out_op,
    output logic              out_zero,
    output logic              out_ones,
    output logic              out_parity,
    output logic [CNT_W-1:0]  op_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = OP_W + 3 + WIDTH;

    logic              s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]   s1_op_q, s1_op_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              accept;
    logic              pop;
    logic [WIDTH-1:0]  eval_res;
    logic              flag_zero;
    logic              flag_ones;
    logic              flag_parity;
    logic [RW-1:0]     push_word;
    logic [RW-1:0]     head_word;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW:0]       occupancy;

    // Space for the S1 beat is reserved up front, so S1 can always drain into
    // the FIFO on the next edge. Only registered state feeds in_ready; full is
    // implied by the occupancy test but kept explicit for readability.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
        in_ready  = !fifo_full && (occupancy < (CW+1)'(DEPTH));
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // S1 capture: loads on accept, otherwise empties (it always drains).
    always_comb begin
        s1_valid_d = accept;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_op_d = in_op;
            s1_a_d  = in_a;
            s1_b_d  = in_b;
        end
    end

    // Evaluate the S1 beat and derive flags at FIFO write time.
    always_comb begin
        eval_res    = WIDTH'(logic_eval(s1_op_q, EVAL_W'(s1_a_q), EVAL_W'(s1_b_q)));
        flag_zero   = (eval_res == '0);
        flag_ones   = &eval_res;
        flag_parity = ^eval_res;
        push_word   = {s1_op_q, flag_zero, flag_ones, flag_parity, eval_res};
    end

    // Completed-operation counter, wraps freely.
    always_comb begin
        op_count_d = op_count_q;
        if (pop) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // Stage registers and pop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            op_count_q <= op_count_d;
        end
    end

    logic_fifo #(
        .DW    (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid_q),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Unpack the FIFO head onto the output ports.
    always_comb begin
        out_valid  = !fifo_empty;
        out_op     = head_word[RW-1 -: OP_W];
        out_zero   = head_word[WIDTH+2];
        out_ones   = head_word[WIDTH+1];
        out_parity = head_word[WIDTH];
        out_result = head_word[WIDTH-1:0];
        op_count   = op_count_q;
    end

endmodule
